// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned WEN_W    = DATA_W / 8;
    localparam int unsigned STARVE_W = 4;
    localparam int unsigned TMO_W    = 8;

    localparam logic [WEN_W-1:0] W_EN_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_e;

    // Access latched at grant time and presented on mem_* for the whole access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WEN_W-1:0]  w_en;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between the core ports, the arbiter and the memory wrapper.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;

    logic              dm_req;
    logic [ADDR_W-1:0] dm_addr;
    logic [WEN_W-1:0]  dm_w_en;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ready;
    logic [DATA_W-1:0] dm_rdata;

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [WEN_W-1:0]  mem_w_en;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    logic              err;
    logic              stall;

    // Arbiter view.
    modport slave (
        input  if_req, if_addr, dm_req, dm_addr, dm_w_en, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata,
        output mem_req, mem_addr, mem_w_en, mem_wdata, err, stall
    );

    // Core and memory-wrapper view.
    modport master (
        output if_req, if_addr, dm_req, dm_addr, dm_w_en, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata,
        input  mem_req, mem_addr, mem_w_en, mem_wdata, err, stall
    );

endinterface

// File: rtl/mem_arb_counter.sv
// Saturating up-counter with synchronous clear and an at-limit flag.
module mem_arb_counter #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_max_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign at_max_c = (cnt_q == W'(MAX));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !at_max_c) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between IF and DM: DM priority, IF starvation guard, access timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e        state_q,    state_d;
    arb_owner_e        owner_q,    owner_d;
    mem_cmd_t          cmd_q,      cmd_d;
    logic              mem_req_q,  mem_req_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic              err_q,      err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic starve_clr, starve_inc, starve_max;
    logic tmo_clr,    tmo_inc,    tmo_max;
    logic grant_dm;

    mem_arb_counter #(.W(STARVE_W), .MAX(STARVE_MAX)) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (starve_clr),
        .inc      (starve_inc),
        .at_max_c (starve_max)
    );

    // Flag rises on the TIMEOUT-th BUSY cycle, since the count starts at 0 on entry.
    mem_arb_counter #(.W(TMO_W), .MAX(TIMEOUT - 1)) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmo_clr),
        .inc      (tmo_inc),
        .at_max_c (tmo_max)
    );

    assign grant_dm = bus.dm_req & ~(bus.if_req & starve_max);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        mem_req_d  = mem_req_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        err_d      = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        starve_clr = 1'b0;
        starve_inc = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (grant_dm) begin
                    owner_d    = OWN_DM;
                    cmd_d      = '{addr: bus.dm_addr, w_en: bus.dm_w_en, wdata: bus.dm_wdata};
                    starve_inc = bus.if_req;
                    starve_clr = ~bus.if_req;
                    tmo_clr    = 1'b1;
                    mem_req_d  = 1'b1;
                    state_d    = ARB_BUSY;
                end else if (bus.if_req) begin
                    owner_d    = OWN_IF;
                    cmd_d      = '{addr: bus.if_addr, w_en: W_EN_NONE, wdata: '0};
                    starve_clr = 1'b1;
                    tmo_clr    = 1'b1;
                    mem_req_d  = 1'b1;
                    state_d    = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                tmo_inc = 1'b1;
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    if (owner_q == OWN_DM) begin
                        dm_ready_d = 1'b1;
                        if (cmd_q.w_en == W_EN_NONE) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else if (tmo_max) begin
                    // Abort: report completion with err set, rdata untouched.
                    mem_req_d  = 1'b0;
                    err_d      = 1'b1;
                    state_d    = ARB_RESP;
                    dm_ready_d = (owner_q == OWN_DM);
                    if_ready_d = (owner_q == OWN_IF);
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWN_IF;
            cmd_q      <= '0;
            mem_req_q  <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            err_q      <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            mem_req_q  <= mem_req_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            err_q      <= err_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_addr  = cmd_q.addr;
    assign bus.mem_w_en  = cmd_q.w_en;
    assign bus.mem_wdata = cmd_q.wdata;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.err       = err_q;
    assign bus.stall     = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule
